l2_write_buffer: RTL and testbench

Posted write-back buffer between the L2 cache and main memory. Dirty-block write-backs from L2 are absorbed into a DEPTH-entry FIFO and acknowledged immediately, so L2 can start its refill read without waiting for the memory write. Reads that hit a buffered block are forwarded from the buffer. Buffered blocks drain to memory in order whenever the memory port is free.

---
 rtl/l2_write_buffer.sv | 188 ++++++++++++++++++
 tb/tb_l2_write_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_write_buffer.sv
// Posted write-back buffer between L2 and main memory: absorbs dirty-block
// write-backs into a small FIFO, forwards read hits, and drains in order.
module l2_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              L2_reset,
  input  logic              L2_read,
  input  logic              L2_write,
  input  logic [ADDR_W-1:0] L2_addr,
  input  logic [DATA_W-1:0] L2_wdata,
  output logic              L2_ready,
  output logic [DATA_W-1:0] L2_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              wb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DEPTH-1:0]    r_valid;
  logic [ADDR_W-1:0]   r_addr [DEPTH];
  logic [DATA_W-1:0]   r_data [DEPTH];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [PTR_W:0]      r_count;
  logic [PTR_W:0]      w_count_nxt;
  logic                r_wb_empty;

  logic                w_req_rd;
  logic                w_req_wr;
  logic                w_full;
  logic [DEPTH-1:0]    w_match;
  logic [DEPTH-1:0]    w_wmatch;
  logic                w_rd_hit;
  logic                w_coalesce;
  logic [PTR_W-1:0]    w_widx;
  logic [DATA_W-1:0]   w_fwd_data;
  logic                w_rd_ok;
  logic                w_miss_idle;
  logic                w_wr_acc;
  logic                w_push;
  logic                w_pop;
  logic                w_rd_done;

  // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_match    = '0;
    w_wmatch   = '0;
    w_widx     = '0;
    w_fwd_data = '0;
    // The head being drained is hidden from write matching so a newer write
    // cannot alter data already presented to memory.
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i]  = r_valid[i] && (r_addr[i] == L2_addr);
      w_wmatch[i] = w_match[i] && !((r_state == DRAIN) && (PTR_W'(i) == r_head));
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (w_match[i]) w_fwd_data = r_data[i];
    end
    // A non-head copy is the newer one; let it win over the draining head.
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wmatch[i]) begin
        w_fwd_data = r_data[i];
        w_widx     = PTR_W'(i);
      end
    end
  end

  assign w_req_rd    = L2_read & ~L2_write;
  assign w_req_wr    = L2_write & ~L2_read;
  assign w_full      = (r_count == FULL_CNT);
  assign w_rd_hit    = |w_match;
  assign w_coalesce  = |w_wmatch;
  assign w_rd_ok     = w_req_rd && w_rd_hit && (r_state != READ);
  assign w_miss_idle = (r_state == IDLE) && w_req_rd && !w_rd_hit;
  assign w_wr_acc    = w_req_wr && !w_full && (r_state != READ);
  assign w_push      = w_wr_acc && !w_coalesce;
  assign w_pop       = (r_state == DRAIN) && mem_ready;
  assign w_rd_done   = (r_state == READ) && mem_ready;
  assign w_count_nxt = r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_miss_idle)         w_state_nxt = READ;
        else if (r_count != '0)  w_state_nxt = DRAIN;
      end
      DRAIN:   if (mem_ready) w_state_nxt = IDLE;
      READ:    if (mem_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    L2_ready  = 1'b0;
    L2_rdata  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!L2_reset) begin
      if (w_wr_acc) L2_ready = 1'b1;
      if (w_rd_ok) begin
        L2_ready = 1'b1;
        L2_rdata = w_fwd_data;
      end
      if (w_rd_done) begin
        L2_ready = 1'b1;
        L2_rdata = mem_rdata;
      end
      unique case (r_state)
        IDLE: begin
          if (w_miss_idle) begin
            mem_read = 1'b1;
            mem_addr = L2_addr;
          end else if (r_count != '0) begin
            mem_write = 1'b1;
            mem_addr  = r_addr[r_head];
            mem_wdata = r_data[r_head];
          end
        end
        DRAIN: begin
          mem_write = 1'b1;
          mem_addr  = r_addr[r_head];
          mem_wdata = r_data[r_head];
        end
        READ: begin
          mem_read = 1'b1;
          mem_addr = L2_addr;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge L2_reset) begin
    if (L2_reset) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_wb_empty <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_wb_empty <= (w_count_nxt == '0) && (w_state_nxt == IDLE);
      // Head and tail never coincide while both move, so these cannot collide.
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
    end
  end

  // NOTE: payload arrays have no reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      if (w_coalesce) begin
        r_data[w_widx] <= L2_wdata;
      end else begin
        r_addr[r_tail] <= L2_addr;
        r_data[r_tail] <= L2_wdata;
      end
    end
  end

  assign wb_empty = r_wb_empty;

endmodule

// File: tb/tb_l2_write_buffer.sv
// Directed bench for l2_write_buffer: per-cycle vector table plus hand-built
// sequences for the full-buffer stall and reset in the middle of a read.
module tb_l2_write_buffer;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic         mrdy;
    logic [127:0] mrdata;
    logic         rdy;
    logic [127:0] rdata;
    logic         mrd;
    logic         mwr;
    logic [27:0]  maddr;
    logic [127:0] mwdata;
    logic         empty;
  } vec_t;

  localparam logic [127:0] DA = 128'hAAAA_0000_1111_2222_3333_4444_5555_000A;
  localparam logic [127:0] DF = 128'hFFFF_0000_1111_2222_3333_4444_5555_000F;
  localparam logic [127:0] DB = 128'hBBBB_0000_1111_2222_3333_4444_5555_000B;
  localparam logic [127:0] DC = 128'hCCCC_0000_1111_2222_3333_4444_5555_000C;
  localparam logic [127:0] DD = 128'hDDDD_0000_1111_2222_3333_4444_5555_000D;
  localparam logic [127:0] DH = 128'h4040_0000_1111_2222_3333_4444_5555_0001;
  localparam logic [127:0] DE = 128'hEEEE_0000_1111_2222_3333_4444_5555_000E;
  localparam logic [127:0] DX = 128'h9999_0000_1111_2222_3333_4444_5555_0009;
  localparam logic [127:0] DY = 128'h6060_0000_1111_2222_3333_4444_5555_0006;
  localparam logic [127:0] R1 = 128'h1234_5678_9ABC_DEF0_0000_0000_0000_0031;
  localparam logic [127:0] R2 = 128'h2234_5678_9ABC_DEF0_0000_0000_0000_0041;
  localparam logic [127:0] R3 = 128'h3234_5678_9ABC_DEF0_0000_0000_0000_0050;

  logic         clk = 1'b0;
  logic         L2_reset;
  logic         L2_read;
  logic         L2_write;
  logic [27:0]  L2_addr;
  logic [127:0] L2_wdata;
  logic         L2_ready;
  logic [127:0] L2_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         wb_empty;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t tbl[$];

  always #5 clk = ~clk;

  l2_write_buffer dut (
    .clk       (clk),
    .L2_reset  (L2_reset),
    .L2_read   (L2_read),
    .L2_write  (L2_write),
    .L2_addr   (L2_addr),
    .L2_wdata  (L2_wdata),
    .L2_ready  (L2_ready),
    .L2_rdata  (L2_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .wb_empty  (wb_empty)
  );

  function automatic vec_t mk(
    input logic rd, input logic wr, input logic [27:0] addr, input logic [127:0] wdata,
    input logic mrdy, input logic [127:0] mrdata,
    input logic rdy, input logic [127:0] rdata, input logic mrd, input logic mwr,
    input logic [27:0] maddr, input logic [127:0] mwdata, input logic empty);
    vec_t v;
    v.rd = rd;   v.wr = wr;     v.addr = addr;   v.wdata = wdata;
    v.mrdy = mrdy; v.mrdata = mrdata;
    v.rdy = rdy; v.rdata = rdata; v.mrd = mrd;   v.mwr = mwr;
    v.maddr = maddr; v.mwdata = mwdata; v.empty = empty;
    return v;
  endfunction

  function automatic logic [127:0] dn(input int n);
    return 128'hF00D_0000_0000_0000_0000_0000_0000_0000 + 128'(n);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, ".L2_ready"},  128'(L2_ready),  128'(v.rdy));
    check({tag, ".L2_rdata"},  L2_rdata,        v.rdata);
    check({tag, ".mem_read"},  128'(mem_read),  128'(v.mrd));
    check({tag, ".mem_write"}, 128'(mem_write), 128'(v.mwr));
    check({tag, ".mem_addr"},  128'(mem_addr),  128'(v.maddr));
    check({tag, ".mem_wdata"}, mem_wdata,       v.mwdata);
    check({tag, ".wb_empty"},  128'(wb_empty),  128'(v.empty));
  endtask

  task automatic drive(input vec_t v);
    L2_read   = v.rd;
    L2_write  = v.wr;
    L2_addr   = v.addr;
    L2_wdata  = v.wdata;
    mem_ready = v.mrdy;
    mem_rdata = v.mrdata;
  endtask

  // One clock cycle: drive after the falling edge, sample before the rising edge.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #2;
    check_outputs(tag, v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a write request active: every output must read 0.
    L2_reset = 1'b1;
    drive(mk(0, 1, 28'h10, DA, 1, R1, 0, 0, 0, 0, 0, 0, 0));
    #12;
    check_outputs("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    L2_reset = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    //          rd wr addr    wdata mrdy mrdata  rdy rdata mrd mwr maddr   mwdata empty
    // single write-back and drain
    tbl.push_back(mk(0, 1, 28'h10, DA, 0, 0,   1, 0,  0, 0, 28'h0,  0,  1));
    tbl.push_back(mk(0, 0, 28'h0,  0,  0, 0,   0, 0,  0, 1, 28'h10, DA, 0));
    tbl.push_back(mk(0, 0, 28'h0,  0,  0, 0,   0, 0,  0, 1, 28'h10, DA, 0));
    tbl.push_back(mk(0, 0, 28'h0,  0,  1, 0,   0, 0,  0, 1, 28'h10, DA, 0));
    tbl.push_back(mk(0, 0, 28'h0,  0,  0, 0,   0, 0,  0, 0, 28'h0,  0,  1));
    // coalesce into a non-head entry
    tbl.push_back(mk(0, 1, 28'h1F, DF, 0, 0,   1, 0,  0, 0, 28'h0,  0,  1));
    tbl.push_back(mk(0, 1, 28'h20, DB, 0, 0,   1, 0,  0, 1, 28'h1F, DF, 0));
    tbl.push_back(mk(0, 1, 28'h20, DC, 0, 0,   1, 0,  0, 1, 28'h1F, DF, 0));
    tbl.push_back(mk(1, 0, 28'h20, 0,  0, 0,   1, DC, 0, 1, 28'h1F, DF, 0));
    tbl.push_back(mk(0, 0, 28'h0,  0,  1, 0,   0, 0,  0, 1, 28'h1F, DF, 0));
    tbl.push_back(mk(0, 0, 28'h0,  0,  0, 0,   0, 0,  0, 1, 28'h20, DC, 0));
    tbl.push_back(mk(0, 0, 28'h0,  0,  1, 0,   0, 0,  0, 1, 28'h20, DC, 0));
    tbl.push_back(mk(0, 0, 28'h0,  0,  0, 0,   0, 0,  0, 0, 28'h0,  0,  1));
    // read miss beats drain in IDLE, then read hits in IDLE and DRAIN
    tbl.push_back(mk(0, 1, 28'h30, DD, 0, 0,   1, 0,  0, 0, 28'h0,  0,  1));
    tbl.push_back(mk(1, 0, 28'h31, 0,  0, 0,   0, 0,  1, 0, 28'h31, 0,  0));
    tbl.push_back(mk(1, 0, 28'h31, 0,  1, R1,  1, R1, 1, 0, 28'h31, 0,  0));
    tbl.push_back(mk(1, 0, 28'h30, 0,  0, 0,   1, DD, 0, 1, 28'h30, DD, 0));
    tbl.push_back(mk(1, 0, 28'h30, 0,  0, 0,   1, DD, 0, 1, 28'h30, DD, 0));
    tbl.push_back(mk(0, 0, 28'h0,  0,  1, 0,   0, 0,  0, 1, 28'h30, DD, 0));
    tbl.push_back(mk(0, 0, 28'h0,  0,  0, 0,   0, 0,  0, 0, 28'h0,  0,  1));
    // write to the draining head allocates; read miss waits out the drain
    tbl.push_back(mk(0, 1, 28'h40, DH, 0, 0,   1, 0,  0, 0, 28'h0,  0,  1));
    tbl.push_back(mk(0, 0, 28'h0,  0,  0, 0,   0, 0,  0, 1, 28'h40, DH, 0));
    tbl.push_back(mk(0, 1, 28'h40, DE, 0, 0,   1, 0,  0, 1, 28'h40, DH, 0));
    tbl.push_back(mk(1, 0, 28'h41, 0,  0, 0,   0, 0,  0, 1, 28'h40, DH, 0));
    tbl.push_back(mk(1, 0, 28'h41, 0,  1, 0,   0, 0,  0, 1, 28'h40, DH, 0));
    tbl.push_back(mk(1, 0, 28'h41, 0,  0, 0,   0, 0,  1, 0, 28'h41, 0,  0));
    tbl.push_back(mk(1, 0, 28'h41, 0,  1, R2,  1, R2, 1, 0, 28'h41, 0,  0));
    tbl.push_back(mk(0, 0, 28'h0,  0,  0, 0,   0, 0,  0, 1, 28'h40, DE, 0));
    tbl.push_back(mk(0, 0, 28'h0,  0,  1, 0,   0, 0,  0, 1, 28'h40, DE, 0));
    tbl.push_back(mk(0, 0, 28'h0,  0,  0, 0,   0, 0,  0, 0, 28'h0,  0,  1));
    // both requests high is idle; stray mem_ready in IDLE is ignored
    tbl.push_back(mk(1, 1, 28'h50, DX, 0, 0,   0, 0,  0, 0, 28'h0,  0,  1));
    tbl.push_back(mk(0, 0, 28'h0,  0,  1, 0,   0, 0,  0, 0, 28'h0,  0,  1));
    tbl.push_back(mk(1, 0, 28'h50, 0,  0, 0,   0, 0,  1, 0, 28'h50, 0,  1));
    tbl.push_back(mk(1, 0, 28'h50, 0,  1, R3,  1, R3, 1, 0, 28'h50, 0,  0));
    tbl.push_back(mk(0, 0, 28'h0,  0,  0, 0,   0, 0,  0, 0, 28'h0,  0,  1));

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Fill the buffer with mem_ready held low, then stall the fifth write.
    for (int n = 1; n <= 4; n++) begin
      run_vec(mk(0, 1, 28'(n), dn(n), 0, 0, 1, 0, 0, (n != 1), (n != 1) ? 28'h1 : 28'h0,
                 (n != 1) ? dn(1) : 128'h0, (n == 1)), $sformatf("fill%0d", n));
    end
    for (int k = 0; k < 3; k++) begin
      run_vec(mk(0, 1, 28'h5, dn(5), 0, 0, 0, 0, 0, 1, 28'h1, dn(1), 0), $sformatf("stall%0d", k));
    end
    run_vec(mk(0, 1, 28'h5, dn(5), 1, 0, 0, 0, 0, 1, 28'h1, dn(1), 0), "full_pop");
    run_vec(mk(0, 1, 28'h5, dn(5), 0, 0, 1, 0, 0, 1, 28'h2, dn(2), 0), "full_accept");
    for (int n = 2; n <= 5; n++) begin
      if (n > 2)
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 28'(n), dn(n), 0), $sformatf("drain%0d_issue", n));
      run_vec(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 28'(n), dn(n), 0), $sformatf("drain%0d_done", n));
    end
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "drain_empty");

    // Reset in the middle of a memory read with a write still buffered.
    run_vec(mk(0, 1, 28'h60, DY, 0, 0, 1, 0, 0, 0, 0, 0, 1), "rst_fill");
    run_vec(mk(1, 0, 28'h61, 0, 0, 0, 0, 0, 1, 0, 28'h61, 0, 0), "rst_miss");
    run_vec(mk(1, 0, 28'h61, 0, 0, 0, 0, 0, 1, 0, 28'h61, 0, 0), "rst_read_wait");
    @(negedge clk);
    L2_reset = 1'b1;
    drive(mk(1, 0, 28'h61, 0, 1, R1, 0, 0, 0, 0, 0, 0, 0));
    #2;
    check_outputs("rst_mid_read", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #2;
    check_outputs("rst_held", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    L2_reset = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), $sformatf("post_rst%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
